// File: rtl/vio_route_ctrl.sv
// -----------------------------------------------------------------------------
// vio_route_ctrl
//
// Holds one route word per vFPGA region. These words drive the route_in port
// of the vFPGA stream switch. Route updates arrive from the control plane. An
// update is applied only at a packet boundary of that region's DTU sink
// stream, so TDEST never changes mid-packet or while a beat is stalled. This
// block only observes the sink handshake; it never drives it.
//
// Ports
//   aclk, areset       clock; synchronous active-high reset
//   cfg_valid/ready    update handshake. cfg_ready = !areset & !route_pend[cfg_id].
//                      A transfer happens on cfg_valid & cfg_ready.
//   cfg_id, cfg_route  target region and new route word
//   mon_tvalid/tready/tlast  per-region snoop of the DTU sink stream
//   route_out          committed route words, region i at [i*ROUTE_BITS +: ROUTE_BITS]
//   route_pend         region holds an uncommitted update
//   route_upd          1-cycle pulse after route_out[i] was loaded
//   dbg_inpkt          packet tracker state per region (1 = INPKT)
// -----------------------------------------------------------------------------
module vio_route_ctrl #(
   parameter int                    N_ID       = 6,
   parameter int                    ROUTE_BITS = 14,
   parameter logic [ROUTE_BITS-1:0] RST_ROUTE  = '0,
   parameter int                    ID_BITS    = (N_ID > 1) ? $clog2(N_ID) : 1
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [ID_BITS-1:0]           cfg_id,
   input  logic [ROUTE_BITS-1:0]        cfg_route,
   input  logic [N_ID-1:0]              mon_tvalid,
   input  logic [N_ID-1:0]              mon_tready,
   input  logic [N_ID-1:0]              mon_tlast,
   output logic [N_ID*ROUTE_BITS-1:0]   route_out,
   output logic [N_ID-1:0]              route_pend,
   output logic [N_ID-1:0]              route_upd,
   output logic [N_ID-1:0]              dbg_inpkt
);

   typedef enum logic {IDLE = 1'b0, INPKT = 1'b1} pkt_state_t;

   pkt_state_t            state      [N_ID];
   logic [ROUTE_BITS-1:0] route_q    [N_ID];
   logic [ROUTE_BITS-1:0] pend_route [N_ID];

   logic [N_ID-1:0] id_hit;
   logic [N_ID-1:0] hs;
   logic [N_ID-1:0] quiet;
   logic            cfg_fire;

   // Decode cfg_id into a one-hot vector. An out-of-range id matches no
   // region. That id then sees cfg_ready=1 and the update is dropped.
   always_comb begin
      id_hit = '0;
      for (int i = 0; i < N_ID; i++) begin
         id_hit[i] = (cfg_id == ID_BITS'(i));
      end
   end

   // A region is quiescent in two cases:
   //   - it sits between packets with no beat offered; or
   //   - its last beat is handshaking this cycle.
   // A stalled beat (tvalid=1, tready=0) is never quiescent. TDEST must
   // stay stable while tvalid is high.
   always_comb begin
      hs        = mon_tvalid & mon_tready;
      quiet     = '0;
      dbg_inpkt = '0;
      for (int i = 0; i < N_ID; i++) begin
         quiet[i]     = ((state[i] == IDLE) && !mon_tvalid[i]) || (hs[i] && mon_tlast[i]);
         dbg_inpkt[i] = (state[i] == INPKT);
      end
   end

   assign cfg_ready = !areset && ((id_hit & route_pend) == '0);
   assign cfg_fire  = cfg_valid && cfg_ready;

   // Packet trackers, pending buffers and committed routes for all regions.
   // No region waits for any other region.
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < N_ID; i++) begin
            state[i]      <= IDLE;
            route_q[i]    <= RST_ROUTE;
            pend_route[i] <= RST_ROUTE;
         end
         route_pend <= '0;
         route_upd  <= '0;
      end else begin
         for (int i = 0; i < N_ID; i++) begin
            route_upd[i] <= 1'b0;

            if (hs[i]) begin
               state[i] <= mon_tlast[i] ? IDLE : INPKT;
            end

            // A new update and a pending commit never coincide for one
            // region. cfg_ready stays low while that region has an entry
            // pending.
            if (cfg_fire && id_hit[i]) begin
               if (quiet[i]) begin
                  route_q[i]   <= cfg_route;
                  route_upd[i] <= 1'b1;
               end else begin
                  pend_route[i] <= cfg_route;
                  route_pend[i] <= 1'b1;
               end
            end else if (route_pend[i] && quiet[i]) begin
               route_q[i]    <= pend_route[i];
               route_pend[i] <= 1'b0;
               route_upd[i]  <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < N_ID; g++) begin : g_route_out
      assign route_out[g*ROUTE_BITS +: ROUTE_BITS] = route_q[g];
   end

endmodule

// File: tb/tb_vio_route_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vio_route_ctrl
//
// Directed bench for vio_route_ctrl with 6 regions and 14-bit routes.
// Inputs are driven 1 ns after the rising edge. Registered outputs are
// sampled at that same point. cfg_ready is combinational, so it is sampled
// 1 ns after the inputs settle. exp_route holds the route each region should
// carry, and it is updated by hand at each commit point.
// -----------------------------------------------------------------------------
module tb_vio_route_ctrl;

   localparam int N_ID = 6;
   localparam int RB   = 14;
   localparam int IDB  = 3;

   logic                 aclk;
   logic                 areset;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [IDB-1:0]       cfg_id;
   logic [RB-1:0]        cfg_route;
   logic [N_ID-1:0]      mon_tvalid;
   logic [N_ID-1:0]      mon_tready;
   logic [N_ID-1:0]      mon_tlast;
   logic [N_ID*RB-1:0]   route_out;
   logic [N_ID-1:0]      route_pend;
   logic [N_ID-1:0]      route_upd;
   logic [N_ID-1:0]      dbg_inpkt;

   logic [RB-1:0] exp_route [N_ID];
   int n_cmp;
   int n_err;

   vio_route_ctrl #(
      .N_ID      (N_ID),
      .ROUTE_BITS(RB),
      .RST_ROUTE (14'h0000)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_id    (cfg_id),
      .cfg_route (cfg_route),
      .mon_tvalid(mon_tvalid),
      .mon_tready(mon_tready),
      .mon_tlast (mon_tlast),
      .route_out (route_out),
      .route_pend(route_pend),
      .route_upd (route_upd),
      .dbg_inpkt (dbg_inpkt)
   );

   // ---------------- clock / watchdog ----------------
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want summary before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [N_ID-1:0] pend_exp,
                            input logic [N_ID-1:0] upd_exp);
      for (int i = 0; i < N_ID; i++) begin
         check($sformatf("%s route[%0d]", tag, i), 32'(route_out[i*RB +: RB]), 32'(exp_route[i]));
      end
      check({tag, " pend"}, 32'(route_pend), 32'(pend_exp));
      check({tag, " upd"},  32'(route_upd),  32'(upd_exp));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic beat(input int r, input logic v, input logic rd, input logic l);
      mon_tvalid[r] = v;
      mon_tready[r] = rd;
      mon_tlast[r]  = l;
   endtask

   task automatic cfg(input logic v, input logic [IDB-1:0] id, input logic [RB-1:0] rt);
      cfg_valid = v;
      cfg_id    = id;
      cfg_route = rt;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < N_ID; i++) exp_route[i] = 14'h0000;
      areset     = 1'b1;
      mon_tvalid = '0;
      mon_tready = '0;
      mon_tlast  = '0;
      cfg(1'b0, 3'd0, 14'h0);

      // Reset state
      tick(); tick();
      check("ready in reset", 32'(cfg_ready), 32'd0);
      check_all("reset", 6'b000000, 6'b000000);
      check("inpkt reset", 32'(dbg_inpkt), 32'd0);
      areset = 1'b0;
      tick();

      // Quiescent update of region 2: commits on the same edge
      cfg(1'b1, 3'd2, 14'h2A3C);
      settle();
      check("t1 ready", 32'(cfg_ready), 32'd1);
      tick();
      cfg(1'b0, 3'd0, 14'h0);
      exp_route[2] = 14'h2A3C;
      check_all("t1 commit", 6'b000000, 6'b000100);
      tick();
      check_all("t1 after", 6'b000000, 6'b000000);

      // Region 0, 4-beat packet; update arrives with beat 2
      beat(0, 1, 1, 0);
      tick();
      check("t2 inpkt", 32'(dbg_inpkt), 32'b000001);
      cfg(1'b1, 3'd0, 14'h1FFC);
      tick();
      cfg(1'b0, 3'd0, 14'h0);
      settle();
      check_all("t2 deferred", 6'b000001, 6'b000000);
      check("t2 ready held", 32'(cfg_ready), 32'd0);
      tick();
      check_all("t2 beat3", 6'b000001, 6'b000000);
      beat(0, 1, 1, 1);
      settle();
      check("t2 ready at last", 32'(cfg_ready), 32'd0);
      tick();
      beat(0, 0, 0, 0);
      exp_route[0] = 14'h1FFC;
      settle();
      check_all("t2 commit", 6'b000000, 6'b000001);
      check("t2 ready back", 32'(cfg_ready), 32'd1);
      check("t2 idle", 32'(dbg_inpkt), 32'd0);
      tick();

      // Region 3, first beat stalled
      beat(3, 1, 0, 0);
      cfg(1'b1, 3'd3, 14'h0333);
      settle();
      check("t3 ready", 32'(cfg_ready), 32'd1);
      tick();
      cfg(1'b0, 3'd0, 14'h0);
      check_all("t3 stalled", 6'b001000, 6'b000000);
      tick(); tick();
      check_all("t3 still stalled", 6'b001000, 6'b000000);
      beat(3, 1, 1, 0);
      tick();
      check_all("t3 first beat", 6'b001000, 6'b000000);
      beat(3, 1, 1, 1);
      tick();
      beat(3, 0, 0, 0);
      exp_route[3] = 14'h0333;
      check_all("t3 commit", 6'b000000, 6'b001000);
      tick();

      // Region 1: update coincides with a single-beat packet
      beat(1, 1, 1, 1);
      cfg(1'b1, 3'd1, 14'h1111);
      tick();
      cfg(1'b0, 3'd0, 14'h0);
      exp_route[1] = 14'h1111;
      check_all("t4 commit", 6'b000000, 6'b000010);
      check("t4 stays idle", 32'(dbg_inpkt), 32'd0);
      tick();
      beat(1, 0, 0, 0);
      check_all("t4 next pkt", 6'b000000, 6'b000000);

      // Out-of-range id: accepted and dropped
      cfg(1'b1, 3'd7, 14'h3ABC);
      settle();
      check("oor ready", 32'(cfg_ready), 32'd1);
      tick();
      cfg(1'b0, 3'd0, 14'h0);
      check_all("oor dropped", 6'b000000, 6'b000000);

      // Region 4: second update held off while one is pending
      beat(4, 1, 1, 0);
      tick();
      beat(4, 0, 0, 0);
      cfg(1'b1, 3'd4, 14'h0444);
      tick();
      cfg(1'b1, 3'd4, 14'h0AAA);
      settle();
      check("t5 ready blocked", 32'(cfg_ready), 32'd0);
      check_all("t5 pending", 6'b010000, 6'b000000);
      tick();
      check_all("t5 held off", 6'b010000, 6'b000000);
      beat(4, 1, 1, 1);
      settle();
      check("t5 ready at last", 32'(cfg_ready), 32'd0);
      tick();
      beat(4, 0, 0, 0);
      exp_route[4] = 14'h0444;
      settle();
      check_all("t5 commit1", 6'b000000, 6'b010000);
      check("t5 ready back", 32'(cfg_ready), 32'd1);
      tick();
      cfg(1'b0, 3'd0, 14'h0);
      exp_route[4] = 14'h0AAA;
      check_all("t5 commit2", 6'b000000, 6'b010000);

      // Regions 0 and 5: simultaneous pending commits
      beat(0, 1, 1, 0);
      beat(5, 1, 1, 0);
      tick();
      beat(0, 0, 0, 0);
      beat(5, 0, 0, 0);
      cfg(1'b1, 3'd0, 14'h0A0A);
      tick();
      cfg(1'b1, 3'd5, 14'h1505);
      tick();
      cfg(1'b0, 3'd0, 14'h0);
      check_all("t6 both pend", 6'b100001, 6'b000000);
      beat(0, 1, 1, 1);
      beat(5, 1, 1, 1);
      tick();
      beat(0, 0, 0, 0);
      beat(5, 0, 0, 0);
      exp_route[0] = 14'h0A0A;
      exp_route[5] = 14'h1505;
      check_all("t6 dual commit", 6'b000000, 6'b100001);
      tick();

      // Reset with region 2 mid-packet and an update pending
      beat(2, 1, 1, 0);
      tick();
      beat(2, 0, 0, 0);
      cfg(1'b1, 3'd2, 14'h3FFF);
      tick();
      cfg(1'b0, 3'd0, 14'h0);
      check_all("t7 pend", 6'b000100, 6'b000000);
      areset = 1'b1;
      settle();
      check("t7 ready in reset", 32'(cfg_ready), 32'd0);
      tick();
      for (int i = 0; i < N_ID; i++) exp_route[i] = 14'h0000;
      check_all("t7 reset", 6'b000000, 6'b000000);
      check("t7 inpkt cleared", 32'(dbg_inpkt), 32'd0);
      areset = 1'b0;
      tick();
      check_all("t7 after reset", 6'b000000, 6'b000000);

      // Tracking was discarded, so region 2 is idle and commits at once
      cfg(1'b1, 3'd2, 14'h0123);
      tick();
      cfg(1'b0, 3'd0, 14'h0);
      exp_route[2] = 14'h0123;
      check_all("t7 post commit", 6'b000000, 6'b000100);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
